// File: rtl/frame_serializer.sv
// Captures a whole windowed frame in one cycle and replays it
// as a sample-per-cycle valid/ready stream with index and last flags.
module frame_serializer #(
    parameter  int DATA_W    = 12,
    parameter  int FRAME_LEN = 128,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] frame_in [0:FRAME_LEN-1],
    input  logic              frame_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [IDX_W-1:0]  sample_index,
    output logic              sample_last,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              capture;
    logic              overrun_next;
    logic              transfer;
    logic              at_last;
    logic [DATA_W-1:0] buffer [0:FRAME_LEN-1];

    assign busy         = (state == STREAM);
    assign sample_valid = busy;
    assign transfer     = busy && sample_ready;
    assign at_last      = (idx == LAST_IDX);
    assign sample_out   = busy ? buffer[idx] : '0;
    assign sample_index = busy ? idx : '0;
    assign sample_last  = busy && at_last;

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        capture      = 1'b0;
        overrun_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_valid) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (transfer && at_last) begin
                    // A frame arriving on the final handshake chains with no bubble
                    if (frame_valid) begin
                        capture  = 1'b1;
                        idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (transfer) begin
                        idx_next = idx + 1'b1;
                    end
                    overrun_next = frame_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            overrun <= overrun_next;
        end
    end

    // Frame storage needs no reset: it is only read while busy
    always_ff @(posedge clk) begin
        if (capture) begin
            buffer <= frame_in;
        end
    end

endmodule
